// File: rtl/yuv422_to_444_interp_pkg.sv
// Shared definitions for the 4:2:2 -> 4:4:4 chroma up-converter.
//   MODE_REPLICATE / MODE_INTERP : chroma reconstruction selector
//   state_t                      : converter sequencing states
//   Y_MIN..C_MAX                 : 8-bit video-range limits, scaled by the user
//   mid_scale()                  : 2^(dw-1), neutral chroma for a given width
package yuv_pkg;

  localparam int MODE_REPLICATE = 0;
  localparam int MODE_INTERP    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] Y_MIN = 8'd16;
  localparam logic [7:0] Y_MAX = 8'd235;
  localparam logic [7:0] C_MIN = 8'd16;
  localparam logic [7:0] C_MAX = 8'd240;

  function automatic int mid_scale(input int dw);
    return 1 << (dw - 1);
  endfunction

endpackage

// File: rtl/yuv422_to_444_interp_chroma_avg.sv
// Rounding average of two DW-bit chroma samples: (iA + iB + 1) >> 1,
// evaluated at DW+1 bits so the carry is never lost. Purely combinational.
//   iA, iB : samples to average
//   oAvg   : rounded mean
module chroma_avg #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] iA,
  input  logic [DW-1:0] iB,
  output logic [DW-1:0] oAvg
);

  logic [DW:0] w_sum;

  assign w_sum = {1'b0, iA} + {1'b0, iB} + (DW+1)'(1);
  assign oAvg  = w_sum[DW:1];

endmodule

// File: rtl/yuv422_to_444_interp.sv
// 4:2:2 -> 4:4:4 chroma up-converter with line framing.
// Each input beat carries {chroma, Y}; chroma alternates C0/C1 with a phase
// that restarts on every accepted iSOL. Output pixel k leaves one cycle after
// input pixel k+3 is accepted, which gives MODE_INTERP the next pair's chroma.
// Optional build macro YUV444_RANGE_CLAMP_EN clamps the output register stage
// to video range; without it values pass through at full range.
// Ports:
//   iCLK, iRST_N          clock, asynchronous active-low reset
//   iValid / oReady       input handshake (oReady low while draining a line)
//   iSOL, iEOL, iYC       line framing and {chroma, Y} beat
//   oValid, oY, oCb, oCr  4:4:4 output pixel
//   oSOL, oEOL            framing aligned to the output pixel
//   oSeqErr               one-cycle pulse on a framing violation
//
// state | meaning
// IDLE  | buffer empty, waiting for iSOL
// FILL  | 1..3 pixels buffered, nothing due yet
// RUN   | 4 pixels buffered, oldest leaves this cycle
// DRAIN | line ended, emptying the buffer, input stalled
module yuv422_to_444_interp
  import yuv_pkg::*;
#(
  parameter int DW       = 8,
  parameter int CB_FIRST = 1,
  parameter int MODE     = MODE_REPLICATE
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iValid,
  output logic          oReady,
  input  logic          iSOL,
  input  logic          iEOL,
  input  logic [2*DW-1:0] iYC,
  output logic          oValid,
  output logic [DW-1:0] oY,
  output logic [DW-1:0] oCb,
  output logic [DW-1:0] oCr,
  output logic          oSOL,
  output logic          oEOL,
  output logic          oSeqErr
);

  localparam logic [DW-1:0] MID = DW'(mid_scale(DW));

  state_t        r_state, w_state_n;
  logic [DW-1:0] r_c [4];
  logic [DW-1:0] r_y [4];
  logic [3:0]    r_ph, r_sl, r_el;
  logic [2:0]    r_cnt;
  logic          r_phase;
  logic [DW-1:0] r_pc0, r_pc1;   // raw chroma of the pair currently leaving
  logic          r_ov, r_osol, r_oeol, r_oerr;
  logic [DW-1:0] r_oy, r_ocb, r_ocr;

  logic          w_ready, w_acc, w_emit, w_discard, w_drop, w_push;
  logic [1:0]    w_wr_idx;
  logic [DW-1:0] w_c0, w_c1, w_n0, w_n1, w_a0, w_a1;
  logic [DW-1:0] w_y, w_cb, w_cr, w_y_fin, w_cb_fin, w_cr_fin;

  assign w_acc     = iValid & w_ready;
  // RUN always releases its oldest pixel, even when a new iSOL arrives:
  // that pixel already had its three followers, only younger ones are lost.
  assign w_emit    = (r_state == RUN) || (r_state == DRAIN);
  assign w_discard = w_acc & iSOL & (r_state != IDLE);
  assign w_drop    = w_acc & ~iSOL & (r_state == IDLE);
  assign w_push    = w_acc & ~w_drop;
  assign w_wr_idx  = w_discard ? 2'd0 : (w_emit ? 2'(r_cnt - 3'd1) : r_cnt[1:0]);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= IDLE;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_ready   = 1'b1;
    case (r_state)
      IDLE:  if (w_push) w_state_n = iEOL ? DRAIN : FILL;
      FILL:  if (w_push) begin
               if (iEOL)                             w_state_n = DRAIN;
               else if (!w_discard && r_cnt == 3'd3) w_state_n = RUN;
             end
      RUN:   if (w_push) w_state_n = iEOL ? DRAIN : (w_discard ? FILL : RUN);
             else        w_state_n = FILL;
      DRAIN: begin
               w_ready = 1'b0;
               if (r_cnt == 3'd1) w_state_n = IDLE;
             end
      default: w_state_n = IDLE;
    endcase
  end

  assign oReady = w_ready;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 4; i++) begin
        r_c[i] <= '0;
        r_y[i] <= '0;
      end
      r_ph    <= '0;
      r_sl    <= '0;
      r_el    <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else begin
      if (w_emit) begin
        for (int i = 0; i < 3; i++) begin
          r_c[i]  <= r_c[i+1];
          r_y[i]  <= r_y[i+1];
          r_ph[i] <= r_ph[i+1];
          r_sl[i] <= r_sl[i+1];
          r_el[i] <= r_el[i+1];
        end
      end
      if (w_push) begin
        r_c[w_wr_idx]  <= iYC[2*DW-1:DW];
        r_y[w_wr_idx]  <= iYC[DW-1:0];
        r_ph[w_wr_idx] <= iSOL ? 1'b0 : r_phase;
        r_sl[w_wr_idx] <= iSOL;
        r_el[w_wr_idx] <= iEOL;
      end
      if (w_acc) r_phase <= iSOL ? 1'b1 : ~r_phase;
      if (w_discard) r_cnt <= 3'd1;
      else           r_cnt <= r_cnt - {2'b0, w_emit} + {2'b0, w_push};
    end
  end

  // Next pair as seen by an odd pixel; when that pair is a lone even pixel
  // ending the line, its missing C1 is this pair's C1.
  assign w_n0 = r_c[1];
  assign w_n1 = r_el[1] ? r_pc1 : r_c[2];

  chroma_avg #(.DW(DW)) u_avg_c0 (.iA(r_pc0), .iB(w_n0), .oAvg(w_a0));
  chroma_avg #(.DW(DW)) u_avg_c1 (.iA(r_pc1), .iB(w_n1), .oAvg(w_a1));

  always_comb begin
    w_c0 = r_c[0];
    w_c1 = r_c[1];
    if (!r_ph[0]) begin
      if (r_el[0]) w_c1 = r_sl[0] ? MID : r_pc1;
    end else begin
      w_c0 = r_pc0;
      w_c1 = r_pc1;
      if (MODE == MODE_INTERP && !r_el[0]) begin
        w_c0 = w_a0;
        w_c1 = w_a1;
      end
    end
  end

  assign w_y  = r_y[0];
  assign w_cb = (CB_FIRST != 0) ? w_c0 : w_c1;
  assign w_cr = (CB_FIRST != 0) ? w_c1 : w_c0;

`ifdef YUV444_RANGE_CLAMP_EN
  localparam logic [DW-1:0] Y_LO = DW'(32'(Y_MIN) << (DW - 8));
  localparam logic [DW-1:0] Y_HI = DW'(32'(Y_MAX) << (DW - 8));
  localparam logic [DW-1:0] C_LO = DW'(32'(C_MIN) << (DW - 8));
  localparam logic [DW-1:0] C_HI = DW'(32'(C_MAX) << (DW - 8));
  assign w_y_fin  = (w_y  < Y_LO) ? Y_LO : ((w_y  > Y_HI) ? Y_HI : w_y);
  assign w_cb_fin = (w_cb < C_LO) ? C_LO : ((w_cb > C_HI) ? C_HI : w_cb);
  assign w_cr_fin = (w_cr < C_LO) ? C_LO : ((w_cr > C_HI) ? C_HI : w_cr);
`else
  assign w_y_fin  = w_y;
  assign w_cb_fin = w_cb;
  assign w_cr_fin = w_cr;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_ov   <= 1'b0;
      r_osol <= 1'b0;
      r_oeol <= 1'b0;
      r_oerr <= 1'b0;
      r_oy   <= '0;
      r_ocb  <= '0;
      r_ocr  <= '0;
      r_pc0  <= '0;
      r_pc1  <= '0;
    end else begin
      r_ov   <= w_emit;
      r_osol <= w_emit & r_sl[0];
      r_oeol <= w_emit & r_el[0];
      r_oerr <= w_discard | w_drop;
      if (w_emit) begin
        r_oy  <= w_y_fin;
        r_ocb <= w_cb_fin;
        r_ocr <= w_cr_fin;
        if (!r_ph[0]) begin
          r_pc0 <= w_c0;
          r_pc1 <= w_c1;
        end
      end
    end
  end

  assign oValid  = r_ov;
  assign oSOL    = r_osol;
  assign oEOL    = r_oeol;
  assign oSeqErr = r_oerr;
  assign oY      = r_oy;
  assign oCb     = r_ocb;
  assign oCr     = r_ocr;

endmodule

// File: tb/tb_yuv422_to_444_interp.sv
// Bench for yuv422_to_444_interp: three instances (replicate/Cb-first,
// interpolate/Cb-first, interpolate/Cr-first) share one randomized stream.
// Expected pixels come from whole-line arithmetic on the accepted beats.
module tb_yuv422_to_444_interp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0, i_sol = 1'b0, i_eol = 1'b0;
  logic [15:0] i_yc = '0;

  logic [2:0] o_v, o_sol, o_eol, o_err, o_rdy;
  logic [7:0] o_y [3];
  logic [7:0] o_cb [3];
  logic [7:0] o_cr [3];

  int n_chk = 0;
  int n_err = 0;
  int exp_seq = 0;
  int seq_obs [3] = '{0, 0, 0};
  logic [25:0] q [3][$];
  logic [25:0] obs [3][$];
  int ln_y [$];
  int ln_c [$];
  bit ln_active = 0;

  always #5 clk = ~clk;

  yuv422_to_444_interp #(.DW(8), .CB_FIRST(1), .MODE(0)) u_rep (
    .iCLK(clk), .iRST_N(rst_n), .iValid(i_valid), .oReady(o_rdy[0]),
    .iSOL(i_sol), .iEOL(i_eol), .iYC(i_yc), .oValid(o_v[0]),
    .oY(o_y[0]), .oCb(o_cb[0]), .oCr(o_cr[0]),
    .oSOL(o_sol[0]), .oEOL(o_eol[0]), .oSeqErr(o_err[0]));

  yuv422_to_444_interp #(.DW(8), .CB_FIRST(1), .MODE(1)) u_int (
    .iCLK(clk), .iRST_N(rst_n), .iValid(i_valid), .oReady(o_rdy[1]),
    .iSOL(i_sol), .iEOL(i_eol), .iYC(i_yc), .oValid(o_v[1]),
    .oY(o_y[1]), .oCb(o_cb[1]), .oCr(o_cr[1]),
    .oSOL(o_sol[1]), .oEOL(o_eol[1]), .oSeqErr(o_err[1]));

  yuv422_to_444_interp #(.DW(8), .CB_FIRST(0), .MODE(1)) u_int_sw (
    .iCLK(clk), .iRST_N(rst_n), .iValid(i_valid), .oReady(o_rdy[2]),
    .iSOL(i_sol), .iEOL(i_eol), .iYC(i_yc), .oValid(o_v[2]),
    .oY(o_y[2]), .oCb(o_cb[2]), .oCr(o_cr[2]),
    .oSOL(o_sol[2]), .oEOL(o_eol[2]), .oSeqErr(o_err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [25:0] pix_of(input int k);
    return {o_sol[k], o_eol[k], o_y[k], o_cb[k], o_cr[k]};
  endfunction

  // C1 of pair n in a line of length L; a lone final even pixel borrows
  // the previous pair's C1, or mid-scale if it is the only pixel.
  function automatic int pair_c1(input int n, input int L);
    if (2*n + 1 < L) return ln_c[2*n + 1];
    if (n > 0)       return ln_c[2*n - 1];
    return 128;
  endfunction

  function automatic int clampv(input int v, input int lo, input int hi);
`ifdef YUV444_RANGE_CLAMP_EN
    return (v < lo) ? lo : ((v > hi) ? hi : v);
`else
    return (lo > hi) ? 0 : v;
`endif
  endfunction

  function automatic logic [25:0] exp_pix(input int mode, input int cbf, input int i, input bit eol_line);
    int L, n, a, b, cb, cr, y;
    L = ln_y.size();
    n = i / 2;
    a = ln_c[2*n];
    b = pair_c1(n, L);
    if (mode == 1 && (i % 2) == 1 && 2*n + 2 < L) begin
      a = (a + ln_c[2*n + 2] + 1) / 2;
      b = (b + pair_c1(n + 1, L) + 1) / 2;
    end
    cb = (cbf != 0) ? a : b;
    cr = (cbf != 0) ? b : a;
    y  = clampv(ln_y[i], 16, 235);
    cb = clampv(cb, 16, 240);
    cr = clampv(cr, 16, 240);
    return {(i == 0), (eol_line && i == L - 1), 8'(y), 8'(cb), 8'(cr)};
  endfunction

  // A terminated line yields every pixel; a line cut short by a new iSOL
  // yields only the pixels that already had three followers.
  task automatic flush_line(input bit eol_line);
    int n;
    n = eol_line ? ln_y.size() : ln_y.size() - 3;
    for (int i = 0; i < n; i++) begin
      q[0].push_back(exp_pix(0, 1, i, eol_line));
      q[1].push_back(exp_pix(1, 1, i, eol_line));
      q[2].push_back(exp_pix(1, 0, i, eol_line));
    end
  endtask

  task automatic model_accept(input int y, input int c, input bit sol, input bit eol);
    if (sol) begin
      if (ln_active) begin
        exp_seq++;
        flush_line(1'b0);
      end
      ln_y.delete();
      ln_c.delete();
      ln_active = 1;
    end else if (!ln_active) begin
      exp_seq++;
      return;
    end
    ln_y.push_back(y);
    ln_c.push_back(c);
    if (eol) begin
      flush_line(1'b1);
      ln_active = 0;
      ln_y.delete();
      ln_c.delete();
    end
  endtask

  task automatic send(input int y, input int c, input bit sol, input bit eol);
    bit r;
    @(negedge clk);
    i_valid = 1'b1;
    i_yc    = {8'(c), 8'(y)};
    i_sol   = sol;
    i_eol   = eol;
    r = 1'b0;
    for (int t = 0; t < 40 && !r; t++) begin
      r = o_rdy[0];
      @(posedge clk);
      if (!r) @(negedge clk);
    end
    #1;
    i_valid = 1'b0;
    i_sol   = 1'b0;
    i_eol   = 1'b0;
    if (r) model_accept(y, c, sol, eol);
    else   chk("ready_timeout", 32'(r), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (o_v[k])   obs[k].push_back(pix_of(k));
        if (o_err[k]) seq_obs[k]++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int sz [3];
    int len;
    bit trunc;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready_%0d", k), 32'(o_rdy[k]), 32'd1);
      chk($sformatf("rst_valid_%0d", k), 32'(o_v[k]), 32'd0);
      chk($sformatf("rst_pix_%0d", k), 32'(pix_of(k)), 32'd0);
      chk($sformatf("rst_err_%0d", k), 32'(o_err[k]), 32'd0);
    end
    rst_n = 1'b1;

    // reference line: latency, handshake and known chroma values
    send(1, 10, 1, 0);
    send(2, 20, 0, 0);
    send(3, 30, 0, 0);
    send(4, 40, 0, 1);
    @(negedge clk);
    chk("drain_ready_low", 32'(o_rdy[0]), 32'd0);
    chk("latency_not_early", 32'(o_v[0]), 32'd0);
    @(negedge clk);
    chk("latency_first_valid", 32'(o_v[0]), 32'd1);
    chk("first_pix_rep", 32'(pix_of(0)), {6'd0, 1'b1, 1'b0, 8'd1, 8'd10, 8'd20});
    @(negedge clk);
    chk("interp_cb", 32'(o_cb[1]), 32'd20);
    chk("interp_cr", 32'(o_cr[1]), 32'd30);
    chk("interp_sw_cb", 32'(o_cb[2]), 32'd30);
    @(negedge clk);
    chk("drain_ready_mid", 32'(o_rdy[0]), 32'd0);
    @(negedge clk);
    chk("last_eol", 32'(o_eol[0]), 32'd1);
    chk("ready_after_drain", 32'(o_rdy[0]), 32'd1);
    idle(3);

    // rounding, short lines, restart, stray beat, range extremes
    send(5, 10, 1, 0); send(6, 77, 0, 0); send(7, 31, 0, 0); send(8, 99, 0, 1);
    idle(2);
    send(1, 10, 1, 0); send(2, 20, 0, 0); send(3, 30, 0, 1);
    idle(2);
    send(9, 55, 1, 1);
    idle(3);
    send(11, 1, 1, 0); send(22, 2, 0, 0);
    send(1, 10, 1, 0); send(2, 20, 0, 0); send(3, 30, 0, 0); send(4, 40, 0, 1);
    idle(6);
    send(50, 50, 0, 0);
    send(5, 250, 1, 0); send(250, 250, 0, 0); send(128, 16, 0, 0); send(235, 240, 0, 1);
    idle(6);

    // randomized lines with input gaps and occasional early restarts
    for (int ln = 0; ln < 60; ln++) begin
      if ($urandom_range(0, 9) == 0) send($urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
      len   = $urandom_range(1, 12);
      trunc = (ln < 59) && ($urandom_range(0, 7) == 0);
      for (int i = 0; i < len; i++) begin
        send($urandom_range(0, 255), $urandom_range(0, 255), i == 0, (i == len - 1) && !trunc);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(12);

    // asynchronous reset while draining: that line is lost
    for (int k = 0; k < 3; k++) sz[k] = q[k].size();
    send(1, 10, 1, 0); send(2, 20, 0, 0); send(3, 30, 0, 0); send(4, 40, 0, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) while (q[k].size() > sz[k]) void'(q[k].pop_back());
    ln_active = 0;
    ln_y.delete();
    ln_c.delete();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("arst_ready_%0d", k), 32'(o_rdy[k]), 32'd1);
      chk($sformatf("arst_valid_%0d", k), 32'(o_v[k]), 32'd0);
      chk($sformatf("arst_pix_%0d", k), 32'(pix_of(k)), 32'd0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    send(7, 100, 1, 0); send(8, 200, 0, 0); send(9, 60, 0, 1);
    idle(12);

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_count_%0d", k), 32'(obs[k].size()), 32'(q[k].size()));
      for (int i = 0; i < obs[k].size() && i < q[k].size(); i++)
        chk($sformatf("pix_%0d_%0d", k, i), 32'(obs[k][i]), 32'(q[k][i]));
      chk($sformatf("seqerr_count_%0d", k), 32'(seq_obs[k]), 32'(exp_seq));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
